banked_regfile_exc: RTL

//  Parametrised ARM-style register file: shared low registers, per-bank copies of the high

---
 rtl/regfile_pkg.sv | 18 +
 rtl/banked_regfile_exc_if.sv | 45 ++++
 rtl/bank_stack.sv | 41 ++++
 rtl/banked_regfile_exc.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the banked register file: widths, special register
// indices and sequencer state codes.
package regfile_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int NUM_BANKS_DEF = 4;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam logic [3:0] REG_LR = 4'd14;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_RUN   = 2'd0;
    localparam fsm_state_t ST_ENTER = 2'd1;
    localparam fsm_state_t ST_EXIT  = 2'd2;

    typedef logic [$clog2(NUM_BANKS_DEF)-1:0] bank_t;

endpackage

// File: rtl/banked_regfile_exc_if.sv
// Decode/EX/WB/fetch-facing bus of the banked register file.
// master = pipeline side, slave = register file.
interface banked_regfile_exc_if #(
    parameter int XLEN      = 32,
    parameter int NUM_BANKS = 4,
    parameter int NUM_RD    = 4
);
    localparam int BW = $clog2(NUM_BANKS);

    logic [4*NUM_RD-1:0]    i_rd_code;
    logic [XLEN*NUM_RD-1:0] o_rd_data;
    logic [XLEN-1:0]        i_pc_next;
    logic                   i_wr_ex_en;
    logic [3:0]             i_wr_ex_code;
    logic [XLEN-1:0]        i_wr_ex_data;
    logic                   i_wr_wb_en;
    logic [3:0]             i_wr_wb_code;
    logic [XLEN-1:0]        i_wr_wb_data;
    logic                   i_exc_req;
    logic [BW-1:0]          i_exc_bank;
    logic                   i_exc_ret;
    logic                   o_exc_ack;
    logic                   o_exc_err;
    logic [BW-1:0]          o_cur_bank;
    logic                   o_busy;
    logic                   o_pc_wr_en;
    logic [XLEN-1:0]        o_pc_wr_data;

    modport master (
        output i_rd_code, i_pc_next,
        output i_wr_ex_en, i_wr_ex_code, i_wr_ex_data,
        output i_wr_wb_en, i_wr_wb_code, i_wr_wb_data,
        output i_exc_req, i_exc_bank, i_exc_ret,
        input  o_rd_data, o_exc_ack, o_exc_err, o_cur_bank, o_busy, o_pc_wr_en, o_pc_wr_data
    );

    modport slave (
        input  i_rd_code, i_pc_next,
        input  i_wr_ex_en, i_wr_ex_code, i_wr_ex_data,
        input  i_wr_wb_en, i_wr_wb_code, i_wr_wb_data,
        input  i_exc_req, i_exc_bank, i_exc_ret,
        output o_rd_data, o_exc_ack, o_exc_err, o_cur_bank, o_busy, o_pc_wr_en, o_pc_wr_data
    );

endinterface

// File: rtl/bank_stack.sv
// LIFO of saved bank indices for nested exceptions; o_top is the most recent push.
module bank_stack
    import regfile_pkg::*;
#(
    parameter int NEST_DEPTH = 3,
    parameter int BW         = 2,
    parameter int DW         = $clog2(NEST_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [BW-1:0] i_din,
    output logic [BW-1:0] o_top,
    output logic [DW-1:0] o_depth,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    logic [NEST_DEPTH-1:0][BW-1:0] r_mem;
    logic [DW-1:0]                 r_depth;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '0;
            r_depth <= '0;
        end else if (i_push && !o_full) begin
            r_mem[AW'(r_depth)] <= i_din;
            r_depth             <= r_depth + DW'(1);
        end else if (i_pop && !o_empty) begin
            r_depth <= r_depth - DW'(1);
        end
    end

    assign o_top   = r_mem[AW'(r_depth - DW'(1))];
    assign o_depth = r_depth;
    assign o_full  = (r_depth == DW'(NEST_DEPTH));
    assign o_empty = (r_depth == '0);

endmodule

// File: rtl/banked_regfile_exc.sv
// ARM-style banked register file with exception entry/return sequencer.
// Optional REGFILE_BYPASS_EN: same-cycle write data forwarded to read ports.
module banked_regfile_exc
    import regfile_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter int              NUM_BANKS  = NUM_BANKS_DEF,
    parameter int              BANKED_LO  = 13,
    parameter int              NUM_RD     = 4,
    parameter int              NEST_DEPTH = 3,
    parameter logic [XLEN-1:0] VEC_BASE   = XLEN'(32'h0000_0018)
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 en,
    banked_regfile_exc_if.slave bus
);
    localparam int BW  = $clog2(NUM_BANKS);
    localparam int DW  = $clog2(NEST_DEPTH + 1);
    localparam int NHI = 15 - BANKED_LO;
    localparam int HW  = (NHI > 1) ? $clog2(NHI) : 1;
    localparam int LW  = (BANKED_LO > 1) ? $clog2(BANKED_LO) : 1;
    localparam logic [HW-1:0] LR_SLOT = HW'(REG_LR - 4'(BANKED_LO));

    logic [BANKED_LO-1:0][XLEN-1:0]          r_lo;
    logic [NUM_BANKS-1:0][NHI-1:0][XLEN-1:0] r_hi;
    fsm_state_t                              r_state;
    logic [BW-1:0]                           r_cur_bank;

    logic              w_run_en, w_wr_ex, w_wr_wb, w_ex_pc, w_wb_pc;
    logic              w_enter_go, w_exit_go, w_err, w_pop;
    logic              w_pc_en;
    logic [XLEN-1:0]   w_pc_data, w_lr_val;
    logic [XLEN*NUM_RD-1:0] w_rd_data;
    logic [BW-1:0]     w_stack_top;
    logic [DW-1:0]     w_depth;
    logic              w_full, w_empty;

    function automatic logic [HW-1:0] hi_slot(input logic [3:0] code);
        return HW'(code - 4'(BANKED_LO));
    endfunction

    function automatic logic [LW-1:0] lo_slot(input logic [3:0] code);
        return LW'(code);
    endfunction

    // Writes only land in RUN with the pipeline advancing; r15 is never stored.
    assign w_run_en = en && (r_state == ST_RUN);
    assign w_wr_ex  = w_run_en && bus.i_wr_ex_en && (bus.i_wr_ex_code != REG_PC);
    assign w_wr_wb  = w_run_en && bus.i_wr_wb_en && (bus.i_wr_wb_code != REG_PC);
    assign w_ex_pc  = w_run_en && bus.i_wr_ex_en && (bus.i_wr_ex_code == REG_PC);
    assign w_wb_pc  = w_run_en && bus.i_wr_wb_en && (bus.i_wr_wb_code == REG_PC);

    // A return request shadows any simultaneous entry request.
    assign w_exit_go  = w_run_en && bus.i_exc_ret && (w_depth != '0);
    assign w_err      = w_run_en && bus.i_exc_ret && w_empty;
    assign w_enter_go = w_run_en && !bus.i_exc_ret && bus.i_exc_req
                        && (bus.i_exc_bank > r_cur_bank) && !w_full;
    assign w_pop      = en && (r_state == ST_EXIT);

    function automatic logic [XLEN-1:0] rd_value(input logic [3:0] code);
        logic [XLEN-1:0] v;
        if (code == REG_PC)
            v = bus.i_pc_next;
        else if (code >= 4'(BANKED_LO))
            v = r_hi[r_cur_bank][hi_slot(code)];
        else
            v = r_lo[lo_slot(code)];
`ifdef REGFILE_BYPASS_EN
        if (code != REG_PC) begin
            if (w_wr_ex && (bus.i_wr_ex_code == code))
                v = bus.i_wr_ex_data;
            else if (w_wr_wb && (bus.i_wr_wb_code == code))
                v = bus.i_wr_wb_data;
        end
`endif
        return v;
    endfunction

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_RD; k++)
            w_rd_data[XLEN*k +: XLEN] = rd_value(bus.i_rd_code[4*k +: 4]);
    end

    always_comb begin
        w_pc_en   = 1'b0;
        w_pc_data = '0;
        case (r_state)
            ST_RUN: begin
                w_pc_en   = w_ex_pc || w_wb_pc;
                w_pc_data = w_wb_pc ? bus.i_wr_wb_data : bus.i_wr_ex_data;
            end
            ST_ENTER: begin
                w_pc_en   = en;
                w_pc_data = VEC_BASE + (XLEN'(r_cur_bank) << 2);
            end
            ST_EXIT: begin
                w_pc_en   = en;
                w_pc_data = r_hi[r_cur_bank][LR_SLOT];
            end
            default: ;
        endcase
    end

    // Return address: a redirect issued in the entry cycle supersedes the sequential PC.
    assign w_lr_val = w_pc_en ? w_pc_data : bus.i_pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_cur_bank <= '0;
        end else if (en) begin
            case (r_state)
                ST_RUN: begin
                    if (w_exit_go) begin
                        r_state <= ST_EXIT;
                    end else if (w_enter_go) begin
                        r_state    <= ST_ENTER;
                        r_cur_bank <= bus.i_exc_bank;
                    end
                end
                ST_ENTER: r_state <= ST_RUN;
                ST_EXIT: begin
                    r_state    <= ST_RUN;
                    r_cur_bank <= w_stack_top;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // EX is applied after WB so it wins on a shared index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo <= '0;
            r_hi <= '0;
        end else begin
            if (w_wr_wb) begin
                if (bus.i_wr_wb_code >= 4'(BANKED_LO))
                    r_hi[r_cur_bank][hi_slot(bus.i_wr_wb_code)] <= bus.i_wr_wb_data;
                else
                    r_lo[lo_slot(bus.i_wr_wb_code)] <= bus.i_wr_wb_data;
            end
            if (w_wr_ex) begin
                if (bus.i_wr_ex_code >= 4'(BANKED_LO))
                    r_hi[r_cur_bank][hi_slot(bus.i_wr_ex_code)] <= bus.i_wr_ex_data;
                else
                    r_lo[lo_slot(bus.i_wr_ex_code)] <= bus.i_wr_ex_data;
            end
            if (w_enter_go)
                r_hi[bus.i_exc_bank][LR_SLOT] <= w_lr_val;
        end
    end

    bank_stack #(
        .NEST_DEPTH (NEST_DEPTH),
        .BW         (BW),
        .DW         (DW)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_enter_go),
        .i_pop   (w_pop),
        .i_din   (r_cur_bank),
        .o_top   (w_stack_top),
        .o_depth (w_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.o_rd_data    = w_rd_data;
    assign bus.o_exc_ack    = w_enter_go;
    assign bus.o_exc_err    = w_err;
    assign bus.o_cur_bank   = r_cur_bank;
    assign bus.o_busy       = (r_state != ST_RUN);
    assign bus.o_pc_wr_en   = w_pc_en;
    assign bus.o_pc_wr_data = w_pc_data;

endmodule
